seq_lock_controller: RTL
========================

// Module: seq_lock_controller
// PURPOSE
//   Combination-lock sequencer for the pushbutton symbol path. Takes one-bit symbols with a valid
//   strobe and compares whole PAT_LEN-symbol attempts against PATTERN (non-overlapping).
//   Drives unlock for a fixed window, counts failed attempts, and enforces a lockout after MAX_FAIL.
//   Sits between the debounced button/symbol source and the lock actuator/status LEDs.
// PARAMETERS
//   PAT_LEN     4        symbols per attempt (>=2)
//   PATTERN     4'b1101  expected code; first symbol = PATTERN[PAT_LEN-1], last = PATTERN[0]
//   MAX_FAIL    3        consecutive failed attempts that trigger lockout (>=1)
//   OPEN_CYC    8        cycles unlock is held high
//   LOCK_CYC    16       cycles locked_out is held high
//   TIMEOUT     32       idle cycles in ENTRY before the attempt is abandoned
// PORTS
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   sym_valid   in   1  one-cycle strobe: sym_bit is valid this cycle
//   sym_bit     in   1  symbol value
//   clear       in   1  synchronous abort of the current attempt or open window
//   unlock      out  1  high while in OPEN
//   locked_out  out  1  high while in LOCKOUT
//   fail_pulse  out  1  one-cycle pulse per failed attempt
//   fail_count  out  W  consecutive failures, W = $clog2(MAX_FAIL+1)
//   state_o     out  2  current state encoding, for debug/LEDs
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, idx=0, mismatch=0, timer=0; all outputs 0.
//   All outputs are registered. unlock/locked_out decode the registered state, so there is no comb path from inputs.
//   States: IDLE=0, ENTRY=1, OPEN=2, LOCKOUT=3.
//   IDLE: sym_valid -> ENTRY; idx<=1; mismatch<=(sym_bit!=PATTERN[PAT_LEN-1]); timer<=TIMEOUT.
//   ENTRY: on sym_valid, compare sym_bit to PATTERN[PAT_LEN-1-idx] and OR the result into mismatch.
//     Each accepted symbol reloads timer to TIMEOUT. A non-final symbol increments idx.
//   The final symbol (idx==PAT_LEN-1) is evaluated with its own compare included:
//     - Match: -> OPEN; timer<=OPEN_CYC; fail_count<=0.
//     - Mismatch: fail_pulse<=1 for one cycle; fail_count<=fail_count+1.
//       If the new count == MAX_FAIL: -> LOCKOUT, timer<=LOCK_CYC. Otherwise -> IDLE.
//   ENTRY with no sym_valid: timer decrements. timer reaching 0 -> IDLE with no failure counted
//     and fail_count unchanged.
//   OPEN: sym_valid is ignored; timer decrements; -> IDLE when the last cycle expires.
//     unlock is high exactly OPEN_CYC cycles.
//   LOCKOUT: sym_valid and clear are ignored; locked_out is high exactly LOCK_CYC cycles.
//     Then -> IDLE with fail_count<=0.
//   Latency: final symbol sampled at edge k -> unlock/fail_pulse/locked_out high from edge k+1.
//   clear (sync): in ENTRY or OPEN -> IDLE with idx=0 and mismatch=0; fail_count unchanged.
//     clear is a no-op in IDLE and in LOCKOUT.
//   clear and sym_valid in the same cycle: clear wins and the symbol is dropped.
//   A symbol in the same cycle as a timeout expiry is accepted: it reloads timer, and the timeout does not fire.
//   fail_count saturates at MAX_FAIL and never wraps.
//   timer width is $clog2(max(OPEN_CYC,LOCK_CYC,TIMEOUT)+1); idx width is $clog2(PAT_LEN).
//   reset asserted mid-attempt, mid-OPEN or mid-LOCKOUT returns immediately to the reset values.
// STRUCTURE
//   Shared package lock_pkg holds:
//     - state encodings S_IDLE/S_ENTRY/S_OPEN/S_LOCKOUT (2 bits);
//     - the width helper for fail_count/timer.
//   Sub-module lock_timer is a loadable down-counter with load, load_val, en and a done flag.
//     There is one instance, shared by the TIMEOUT, OPEN and LOCKOUT windows.
//   The FSM, idx/mismatch registers and fail counter live in the top module.
// TESTING
//   1 Reset, then symbols 1,1,0,1 on consecutive cycles:
//     unlock high for exactly 8 cycles starting the cycle after the 4th symbol; fail_count=0.
//   2 Symbols 1,0,0,1:
//     fail_pulse is a single 1-cycle pulse after the 4th symbol; fail_count=1; state=IDLE; unlock stays 0.
//   3 Three wrong attempts (1,0,0,1 x3):
//     locked_out=1 for 16 cycles; 1,1,0,1 sent during LOCKOUT gives no unlock.
//     After lockout fail_count=0, and 1,1,0,1 then unlocks.
//   4 Symbols 1,1, then 40 idle cycles, then 0,1:
//     timeout at 32 cycles returns to IDLE; 0,1 starts a fresh attempt; no fail_pulse and no unlock.
//   5 Symbols 1,1,0 with clear on the 4th symbol's cycle:
//     state=IDLE, no evaluation; a following 1,1,0,1 unlocks.
//   6 Drive reset low during OPEN cycle 3 and during LOCKOUT cycle 5:
//     unlock/locked_out drop asynchronously; all outputs 0 and state_o=0 while reset=0.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encodings and width helpers for the combination-lock sequencer.
package lock_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry-timeout, open and lockout windows.
// done marks the last counted cycle of a window (count==1); load has priority over en.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/seq_lock_controller.sv
// Combination-lock sequencer: whole-attempt compare, timed unlock, fail count and lockout.
// Outputs change one edge after the deciding symbol; no input-to-output comb path.
module seq_lock_controller
  import lock_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1101,
  parameter int                 MAX_FAIL = 3,
  parameter int                 OPEN_CYC = 8,
  parameter int                 LOCK_CYC = 16,
  parameter int                 TIMEOUT  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sym_valid,
  input  logic                         sym_bit,
  input  logic                         clear,
  output logic                         unlock,
  output logic                         locked_out,
  output logic                         fail_pulse,
  output logic [cnt_w(MAX_FAIL)-1:0]   fail_count,
  output logic [1:0]                   state_o
);

  localparam int FC_W  = cnt_w(MAX_FAIL);
  localparam int TMR_W = cnt_w(max3(OPEN_CYC, LOCK_CYC, TIMEOUT));
  localparam int IDX_W = $clog2(PAT_LEN);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              mismatch, mismatch_n;
  logic [FC_W-1:0]   fc_n, fc_inc;
  logic              fp_n;
  logic              t_load, t_en, t_done;
  logic [TMR_W-1:0]  t_val;
  logic [PAT_LEN-1:0] pat_rev;
  logic              cur_mis;

  // pat_rev[i] is the symbol expected at position i of an attempt.
  for (genvar g = 0; g < PAT_LEN; g++) begin : g_rev
    assign pat_rev[g] = PATTERN[PAT_LEN-1-g];
  end

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      mismatch   <= 1'b0;
      fail_count <= '0;
      fail_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      mismatch   <= mismatch_n;
      fail_count <= fc_n;
      fail_pulse <= fp_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mismatch_n = mismatch;
    fc_n       = fail_count;
    fp_n       = 1'b0;
    t_load     = 1'b0;
    t_val      = '0;
    t_en       = 1'b0;
    cur_mis    = mismatch | (sym_bit != pat_rev[idx]);
    fc_inc     = (fail_count == FC_W'(MAX_FAIL)) ? fail_count : fail_count + FC_W'(1);

    unique case (state)
      S_IDLE: begin
        if (sym_valid) begin
          state_n    = S_ENTRY;
          idx_n      = IDX_W'(1);
          mismatch_n = (sym_bit != pat_rev[0]);
          t_load     = 1'b1;
          t_val      = TMR_W'(TIMEOUT);
        end
      end
      S_ENTRY: begin
        if (clear) begin
          state_n    = S_IDLE;
          idx_n      = '0;
          mismatch_n = 1'b0;
        end else if (sym_valid) begin
          t_load = 1'b1;
          t_val  = TMR_W'(TIMEOUT);
          if (idx == IDX_W'(PAT_LEN-1)) begin
            idx_n      = '0;
            mismatch_n = 1'b0;
            if (!cur_mis) begin
              state_n = S_OPEN;
              t_val   = TMR_W'(OPEN_CYC);
              fc_n    = '0;
            end else begin
              fp_n = 1'b1;
              fc_n = fc_inc;
              if (fc_inc == FC_W'(MAX_FAIL)) begin
                state_n = S_LOCKOUT;
                t_val   = TMR_W'(LOCK_CYC);
              end else begin
                state_n = S_IDLE;
              end
            end
          end else begin
            idx_n      = idx + IDX_W'(1);
            mismatch_n = cur_mis;
          end
        end else begin
          t_en = 1'b1;
          if (t_done) begin
            state_n    = S_IDLE;
            idx_n      = '0;
            mismatch_n = 1'b0;
          end
        end
      end
      S_OPEN: begin
        t_en = 1'b1;
        if (clear || t_done) begin
          state_n    = S_IDLE;
          idx_n      = '0;
          mismatch_n = 1'b0;
        end
      end
      S_LOCKOUT: begin
        t_en = 1'b1;
        if (t_done) begin
          state_n = S_IDLE;
          fc_n    = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign unlock     = (state == S_OPEN);
  assign locked_out = (state == S_LOCKOUT);
  assign state_o    = state;

endmodule
